// File: rtl/tft_pkg.sv
// Shared types and constants for the TFT display write path.
// Holds default geometry, address widths, pixel word type and state enum.
package tft_pkg;

    localparam int H_PIX_DEF = 800;
    localparam int V_PIX_DEF = 480;

    localparam int PAGE_W = 3;
    localparam int ROW_W  = 9;
    localparam int COL_W  = 10;

    typedef logic [15:0] rgb565_t;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

endpackage

// File: rtl/pix_fifo.sv
// Show-ahead synchronous FIFO: head word is always visible on dout.
// Ports: push/pop/flush controls, din/dout data, count of stored words.
module pix_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [AW-1:0]    wr_idx;

    // A push coinciding with a flush lands in slot 0 of the emptied buffer.
    assign wr_idx = flush ? '0 : wr_q[AW-1:0];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            rd_d = '0;
            wr_d = {{AW{1'b0}}, push};
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx] <= din;
    end

    assign dout  = mem_q[rd_q[AW-1:0]];
    assign count = wr_q - rd_q;

endmodule

// File: rtl/tft_pixel_feeder.sv
// Write-side feeder: buffers host RGB565 pixels and walks the SDRAM write address.
// Ports: pix_* host handshake, FIFO_* controller side, page/row/col address, status.
import tft_pkg::*;

module tft_pixel_feeder #(
    parameter int      H_PIX       = H_PIX_DEF,
    parameter int      V_PIX       = V_PIX_DEF,
    parameter int      FIFO_DEPTH  = 16,
    parameter rgb565_t CLEAR_COLOR = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              frame_start,
    input  logic              clear_req,
    input  logic [PAGE_W-1:0] page_sel,
    output logic [PAGE_W-1:0] page_set,
    output logic [ROW_W-1:0]  row_add_user,
    output logic [COL_W-1:0]  col_add_user,
    output logic [15:0]       FIFO_out,
    output logic              FIFO_full,
    input  logic              FIFO_RD_req,
    input  logic              startup_inc,
    output logic              startup,
    output logic              frame_done,
    output logic              underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    state_e            state_q, state_d;
    logic              startup_q, startup_d;
    logic              frame_done_q, frame_done_d;
    logic              underflow_q, underflow_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;

    logic          run, clr, fst;
    logic          has_room, fifo_empty;
    logic          push, pop, flush;
    logic          col_last, row_last;
    logic [AW:0]   count;
    rgb565_t       fifo_dout;

    assign run = (state_q == ST_RUN);
    assign clr = run & clear_req;
    assign fst = run & frame_start & ~clear_req;

    assign fifo_empty = (count == '0);
    assign has_room   = (count != (AW+1)'(FIFO_DEPTH));

    // A word offered while full is taken if a pop frees a slot the same cycle.
    assign pop   = run & FIFO_RD_req & ~fifo_empty;
    assign push  = run & pix_valid & (has_room | pop) & ~clr;
    assign flush = clr | fst;

    pix_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (pix_data),
        .dout  (fifo_dout),
        .count (count)
    );

    assign col_last = (col_q == COL_W'(H_PIX - 1));
    assign row_last = (row_q == ROW_W'(V_PIX - 1));

    always_comb begin
        state_d      = state_q;
        startup_d    = startup_q;
        frame_done_d = 1'b0;
        underflow_d  = underflow_q | (FIFO_RD_req & fifo_empty);
        page_d       = page_q;
        row_d        = row_q;
        col_d        = col_q;

        // Clear pass completes the cycle after its final wrap.
        if (!run && frame_done_q) begin
            state_d   = ST_RUN;
            startup_d = 1'b1;
        end

        if (clr) begin
            state_d   = ST_CLEAR;
            startup_d = 1'b0;
            page_d    = page_sel;
            row_d     = '0;
            col_d     = '0;
        end else if (fst) begin
            page_d = page_sel;
            row_d  = '0;
            col_d  = '0;
        end else if (startup_inc) begin
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_CLEAR;
            startup_q    <= 1'b0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
            page_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
        end else begin
            state_q      <= state_d;
            startup_q    <= startup_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
            page_q       <= page_d;
            row_q        <= row_d;
            col_q        <= col_d;
        end
    end

    assign pix_ready    = run & has_room;
    assign FIFO_full    = run & ~fifo_empty;
    assign FIFO_out     = run ? fifo_dout : CLEAR_COLOR;
    assign page_set     = page_q;
    assign row_add_user = row_q;
    assign col_add_user = col_q;
    assign startup      = startup_q;
    assign frame_done   = frame_done_q;
    assign underflow    = underflow_q;

endmodule
